// File: rtl/obi_sram_pkg.sv
// Shared types and limits for the OBI-to-SRAM controller.
package obi_sram_pkg;

    localparam int WORD_BYTES      = 4;
    localparam int MAX_WAIT_STATES = 7;
    localparam int CNT_W           = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/obi_sram_ctrl_if.sv
// OBI request/response bundle between the bridge (master) and the SRAM controller (slave).
// err_o is only present when OBI_SRAM_ERR_EN is defined.
interface obi_sram_ctrl_if;

    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
`ifdef OBI_SRAM_ERR_EN
    logic        err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
`else
    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
`endif

endinterface

// File: rtl/obi_sram_ctrl.sv
// OBI slave driving a single-port synchronous SRAM macro with optional wait states.
// Define OBI_SRAM_ERR_EN to enable the address window check and err_o.
module obi_sram_ctrl
    import obi_sram_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              wb_rst_i,
    obi_sram_ctrl_if.slave    bus,
    output logic              sram_csb_o,
    output logic              sram_web_o,
    output logic [3:0]        sram_wmask_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_din_o,
    input  logic [31:0]       sram_dout_i
);

    localparam int                 WS_CLAMP = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
    localparam logic [CNT_W-1:0]   WAIT_CNT = CNT_W'(WS_CLAMP);
    localparam bit                 NO_WAIT  = (WS_CLAMP == 0);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [3:0]        be;
        logic [31:0]       wdata;
        logic              err;
    } access_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    access_t           hold_q;
    access_t           req_s;
    access_t           acc;
    logic              active;
    logic              gnt;
    logic              addr_err;
    logic              rsp_valid_q, rsp_we_q, rsp_err_q;
    logic              rsp_valid_d, rsp_we_d, rsp_err_d;
    logic              rvalid;

`ifdef OBI_SRAM_ERR_EN
    localparam logic [31:0] WINDOW_MASK = ~(32'(WORD_BYTES * DEPTH) - 32'd1);
    logic unused_byte_offset;

    assign addr_err           = (bus.addr_i & WINDOW_MASK) != BASE_ADDR;
    assign unused_byte_offset = ^bus.addr_i[1:0];
`else
    logic unused_cfg;

    // Without the window check the upper address bits simply alias.
    assign addr_err   = 1'b0;
    assign unused_cfg = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0], BASE_ADDR, 32'(DEPTH)};
`endif

    always_comb begin
        req_s.addr  = bus.addr_i[ADDR_W+1:2];
        req_s.we    = bus.we_i;
        req_s.be    = bus.be_i;
        req_s.wdata = bus.wdata_i;
        req_s.err   = addr_err;
    end

    always_ff @(posedge clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_i && !NO_WAIT) state_d = BUSY;
            BUSY:    if (cnt_q == CNT_W'(1))    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Cycle A drives the macro straight from the bus; wait cycles replay the held copy.
    always_comb begin
        gnt    = 1'b0;
        active = 1'b0;
        acc    = req_s;
        case (state_q)
            IDLE: begin
                gnt    = bus.req_i;
                active = bus.req_i;
            end
            BUSY: begin
                active = 1'b1;
                acc    = hold_q;
            end
            default: ;
        endcase
        if (wb_rst_i) begin
            gnt    = 1'b0;
            active = 1'b0;
        end
    end

    assign sram_csb_o   = !(active && !acc.err);
    assign sram_web_o   = !(active && !acc.err && acc.we);
    assign sram_wmask_o = (active && !acc.err && acc.we) ? acc.be : 4'b0000;
    assign sram_addr_o  = acc.addr;
    assign sram_din_o   = acc.wdata;

    assign rsp_valid_d = ((state_q == IDLE) && bus.req_i && NO_WAIT)
                       || ((state_q == BUSY) && (cnt_q == CNT_W'(1)));
    assign rsp_we_d    = NO_WAIT ? req_s.we  : hold_q.we;
    assign rsp_err_d   = NO_WAIT ? req_s.err : hold_q.err;

    always_ff @(posedge clk_i) begin
        if (wb_rst_i) begin
            cnt_q       <= '0;
            hold_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
            if ((state_q == IDLE) && bus.req_i) begin
                hold_q <= req_s;
                cnt_q  <= WAIT_CNT;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign rvalid       = rsp_valid_q && !wb_rst_i;
    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid;
    // The macro output is only meaningful for a successful read response.
    assign bus.rdata_o  = (rvalid && !rsp_we_q && !rsp_err_q) ? sram_dout_i : 32'h0;
`ifdef OBI_SRAM_ERR_EN
    assign bus.err_o    = rvalid && rsp_err_q;
`endif

endmodule

// File: tb/tb_obi_sram_ctrl.sv
// Directed bench for obi_sram_ctrl: three instances (0, 2 and 3 wait states) with behavioural SRAMs.
// Optional checks for the address window run when OBI_SRAM_ERR_EN is defined.
module tb_obi_sram_ctrl;

    typedef struct {
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          gnt;
        bit          rvalid;
        logic [31:0] rdata;
        bit          csb;
        logic [3:0]  wmask;
    } vec_t;

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
        logic        csb;
        logic        web;
        logic [3:0]  wmask;
        logic [7:0]  addr;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst2, rst3;
    obi_sram_ctrl_if bus0();
    obi_sram_ctrl_if bus2();
    obi_sram_ctrl_if bus3();

    logic        csb0, web0, csb2, web2, csb3, web3;
    logic [3:0]  wmask0, wmask2, wmask3;
    logic [7:0]  addr0, addr2, addr3;
    logic [31:0] din0, din2, din3;
    logic [31:0] dout0, dout2, dout3;
    logic [31:0] mem0 [256];
    logic [31:0] mem2 [256];
    logic [31:0] mem3 [256];

    obi_sram_ctrl #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk_i(clk), .wb_rst_i(rst0), .bus(bus0),
        .sram_csb_o(csb0), .sram_web_o(web0), .sram_wmask_o(wmask0),
        .sram_addr_o(addr0), .sram_din_o(din0), .sram_dout_i(dout0)
    );

    obi_sram_ctrl #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut2 (
        .clk_i(clk), .wb_rst_i(rst2), .bus(bus2),
        .sram_csb_o(csb2), .sram_web_o(web2), .sram_wmask_o(wmask2),
        .sram_addr_o(addr2), .sram_din_o(din2), .sram_dout_i(dout2)
    );

    obi_sram_ctrl #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
        .clk_i(clk), .wb_rst_i(rst3), .bus(bus3),
        .sram_csb_o(csb3), .sram_web_o(web3), .sram_wmask_o(wmask3),
        .sram_addr_o(addr3), .sram_din_o(din3), .sram_dout_i(dout3)
    );

    // Behavioural macros: dout registers the addressed word on every enabled read cycle.
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++) if (wmask0[b]) mem0[addr0][8*b +: 8] <= din0[8*b +: 8];
            end else dout0 <= mem0[addr0];
        end
    end

    always @(posedge clk) begin
        if (!csb2) begin
            if (!web2) begin
                for (int b = 0; b < 4; b++) if (wmask2[b]) mem2[addr2][8*b +: 8] <= din2[8*b +: 8];
            end else dout2 <= mem2[addr2];
        end
    end

    always @(posedge clk) begin
        if (!csb3) begin
            if (!web3) begin
                for (int b = 0; b < 4; b++) if (wmask3[b]) mem3[addr3][8*b +: 8] <= din3[8*b +: 8];
            end else dout3 <= mem3[addr3];
        end
    end

    int errors = 0;
    int checks = 0;
    vec_t vecs [11];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int d, input bit req, input bit we, input logic [31:0] addr,
                                  input logic [3:0] be, input logic [31:0] wdata);
        case (d)
            0: begin bus0.req_i = req; bus0.we_i = we; bus0.addr_i = addr; bus0.be_i = be; bus0.wdata_i = wdata; end
            2: begin bus2.req_i = req; bus2.we_i = we; bus2.addr_i = addr; bus2.be_i = be; bus2.wdata_i = wdata; end
            default: begin bus3.req_i = req; bus3.we_i = we; bus3.addr_i = addr; bus3.be_i = be; bus3.wdata_i = wdata; end
        endcase
    endtask

    function automatic obs_t sample(input int d);
        obs_t o;
        o.err = 1'b0;
        case (d)
            0: begin
                o.gnt = bus0.gnt_o; o.rvalid = bus0.rvalid_o; o.rdata = bus0.rdata_o;
                o.csb = csb0; o.web = web0; o.wmask = wmask0; o.addr = addr0;
`ifdef OBI_SRAM_ERR_EN
                o.err = bus0.err_o;
`endif
            end
            2: begin
                o.gnt = bus2.gnt_o; o.rvalid = bus2.rvalid_o; o.rdata = bus2.rdata_o;
                o.csb = csb2; o.web = web2; o.wmask = wmask2; o.addr = addr2;
`ifdef OBI_SRAM_ERR_EN
                o.err = bus2.err_o;
`endif
            end
            default: begin
                o.gnt = bus3.gnt_o; o.rvalid = bus3.rvalid_o; o.rdata = bus3.rdata_o;
                o.csb = csb3; o.web = web3; o.wmask = wmask3; o.addr = addr3;
`ifdef OBI_SRAM_ERR_EN
                o.err = bus3.err_o;
`endif
            end
        endcase
        return o;
    endfunction

    // One isolated transaction: grant in cycle A, then a bounded wait for the single response pulse.
    task automatic run_txn(input int d, input bit we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rdata,
                           input bit exp_csb, input bit exp_err, input string name);
        obs_t o;
        int   lat = 0;
        @(posedge clk); #1;
        apply_stimulus(d, 1'b1, we, addr, be, wdata);
        @(negedge clk);
        o = sample(d);
        check_output({name, " gnt"}, 32'(o.gnt), 32'd1);
        check_output({name, " csb"}, 32'(o.csb), 32'(exp_csb));
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (n == 1) apply_stimulus(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            @(negedge clk);
            o = sample(d);
            if (o.rvalid === 1'b1) begin
                lat = n;
                check_output({name, " rdata"}, o.rdata, exp_rdata);
`ifdef OBI_SRAM_ERR_EN
                check_output({name, " err"}, 32'(o.err), 32'(exp_err));
`else
                if (exp_err) check_output({name, " err"}, 32'(o.err), 32'(exp_err));
`endif
            end
        end
        check_output({name, " latency"}, 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
        @(negedge clk);
        o = sample(d);
        check_output({name, " single pulse"}, 32'(o.rvalid), 32'd0);
    endtask

    initial begin
        obs_t o;
        int   cnt;
        int   lat;

        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'hC0DE_0000 + 32'(i);
            mem2[i] = 32'hC0DE_0000 + 32'(i);
            mem3[i] = 32'hC0DE_0000 + 32'(i);
        end

        vecs[0]  = '{1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0, 4'hF};
        vecs[1]  = '{1'b1, 1'b0, 32'h10, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 4'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 4'h0};
        vecs[3]  = '{1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b1, 1'b0, 32'h0,        1'b0, 4'hF};
        vecs[4]  = '{1'b1, 1'b1, 32'h20, 4'h2, 32'h0000AB00, 1'b1, 1'b1, 32'h0,        1'b0, 4'h2};
        vecs[5]  = '{1'b1, 1'b0, 32'h20, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 4'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b1, 32'h1122AB44, 1'b1, 4'h0};
        vecs[7]  = '{1'b1, 1'b1, 32'h24, 4'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,        1'b0, 4'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h12, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 4'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h24, 4'hF, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 4'h0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b1, 32'hC0DE0009, 1'b1, 4'h0};

        rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        apply_stimulus(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h12345678);
        apply_stimulus(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        apply_stimulus(3, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);

        // Reset holds every output quiet even with a live request.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        o = sample(0);
        check_output("reset gnt", 32'(o.gnt), 32'd0);
        check_output("reset rvalid", 32'(o.rvalid), 32'd0);
        check_output("reset rdata", o.rdata, 32'h0);
        check_output("reset csb", 32'(o.csb), 32'd1);
        check_output("reset web", 32'(o.web), 32'd1);
        check_output("reset wmask", 32'(o.wmask), 32'd0);
        check_output("reset err", 32'(o.err), 32'd0);
        o = sample(3);
        check_output("reset ws3 gnt", 32'(o.gnt), 32'd0);
        check_output("reset ws3 csb", 32'(o.csb), 32'd1);

        @(posedge clk); #1;
        rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        apply_stimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        apply_stimulus(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            apply_stimulus(0, vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata);
            @(negedge clk);
            o = sample(0);
            check_output($sformatf("vec%0d gnt", i), 32'(o.gnt), 32'(vecs[i].gnt));
            check_output($sformatf("vec%0d rvalid", i), 32'(o.rvalid), 32'(vecs[i].rvalid));
            check_output($sformatf("vec%0d rdata", i), o.rdata, vecs[i].rdata);
            check_output($sformatf("vec%0d csb", i), 32'(o.csb), 32'(vecs[i].csb));
            check_output($sformatf("vec%0d wmask", i), 32'(o.wmask), 32'(vecs[i].wmask));
            check_output($sformatf("vec%0d web", i), 32'(o.web),
                         32'(vecs[i].req ? !vecs[i].we : 1'b1));
        end

        // Zero wait states: 8 alternating write/read transactions with req held high.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i < 8) apply_stimulus(0, 1'b1, (i % 2) == 0, 32'h80 + 32'(4 * (i / 2)), 4'hF,
                                      32'h1000_0000 + 32'(i * 32'h111));
            else       apply_stimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            @(negedge clk);
            o = sample(0);
            check_output($sformatf("b2b%0d gnt", i), 32'(o.gnt), 32'(i < 8));
            check_output($sformatf("b2b%0d rvalid", i), 32'(o.rvalid), 32'((i >= 1) && (i <= 8)));
            if ((i >= 1) && (i <= 8))
                check_output($sformatf("b2b%0d rdata", i), o.rdata,
                             ((i - 1) % 2 == 0) ? 32'h0 : 32'h1000_0000 + 32'((i - 2) * 32'h111));
        end

        // Three wait states, request held high; changes while gnt=0 must not reach the macro.
        @(posedge clk); #1;
        apply_stimulus(3, 1'b1, 1'b0, 32'h08, 4'hF, 32'h0);
        @(negedge clk);
        o = sample(3);
        check_output("ws3 A gnt", 32'(o.gnt), 32'd1);
        check_output("ws3 A csb", 32'(o.csb), 32'd0);
        check_output("ws3 A addr", 32'(o.addr), 32'd2);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 1) apply_stimulus(3, 1'b1, 1'b1, 32'h0C, 4'hF, 32'hFFFFFFFF);
            if (k == 3) apply_stimulus(3, 1'b1, 1'b0, 32'h0C, 4'hF, 32'h0);
            @(negedge clk);
            o = sample(3);
            check_output($sformatf("ws3 A+%0d gnt", k), 32'(o.gnt), 32'd0);
            check_output($sformatf("ws3 A+%0d csb", k), 32'(o.csb), 32'd0);
            check_output($sformatf("ws3 A+%0d web", k), 32'(o.web), 32'd1);
            check_output($sformatf("ws3 A+%0d addr", k), 32'(o.addr), 32'd2);
            check_output($sformatf("ws3 A+%0d rvalid", k), 32'(o.rvalid), 32'd0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        o = sample(3);
        check_output("ws3 A+4 rvalid", 32'(o.rvalid), 32'd1);
        check_output("ws3 A+4 rdata", o.rdata, 32'hC0DE0002);
        check_output("ws3 A+4 gnt", 32'(o.gnt), 32'd1);
        check_output("ws3 A+4 addr", 32'(o.addr), 32'd3);
        lat = 0;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (n == 1) apply_stimulus(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            @(negedge clk);
            o = sample(3);
            if (o.rvalid === 1'b1) begin
                lat = n;
                check_output("ws3 second rdata", o.rdata, 32'hC0DE0003);
            end
        end
        check_output("ws3 second latency", 32'(lat), 32'd4);

        run_txn(3, 1'b1, 32'h30, 4'h2, 32'h0000AB00, 4, 32'h0, 1'b0, 1'b0, "ws3 byte write");
        run_txn(3, 1'b0, 32'h30, 4'hF, 32'h0, 4, 32'hC0DEAB0C, 1'b0, 1'b0, "ws3 readback");

        // Reset in A+1 of a two-wait-state read drops the response.
        @(posedge clk); #1;
        apply_stimulus(2, 1'b1, 1'b0, 32'h14, 4'hF, 32'h0);
        @(negedge clk);
        o = sample(2);
        check_output("rst A gnt", 32'(o.gnt), 32'd1);
        @(posedge clk); #1;
        rst2 = 1'b1;
        @(negedge clk);
        o = sample(2);
        check_output("rst A+1 gnt", 32'(o.gnt), 32'd0);
        check_output("rst A+1 csb", 32'(o.csb), 32'd1);
        check_output("rst A+1 rvalid", 32'(o.rvalid), 32'd0);
        @(posedge clk); #1;
        rst2 = 1'b0;
        apply_stimulus(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus2.rvalid_o === 1'b1) cnt++;
            @(posedge clk); #1;
        end
        check_output("rst dropped rvalid count", 32'(cnt), 32'd0);
        run_txn(2, 1'b0, 32'h18, 4'hF, 32'h0, 3, 32'hC0DE0006, 1'b0, 1'b0, "post-reset read");

`ifdef OBI_SRAM_ERR_EN
        run_txn(0, 1'b0, 32'h400, 4'hF, 32'h0, 1, 32'h0, 1'b1, 1'b1, "err out of range");
        run_txn(0, 1'b0, 32'h3FC, 4'hF, 32'h0, 1, 32'hC0DE00FF, 1'b0, 1'b0, "err in range");
`else
        run_txn(0, 1'b0, 32'h410, 4'hF, 32'h0, 1, 32'hDEADBEEF, 1'b0, 1'b0, "alias read");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
